// File: rtl/game_sequencer_if.sv
// Signal bundle between the key filter / snake datapath and game_sequencer.
// The master side is the sequencer; the slave side is the datapath or the bench.
interface game_sequencer_if;
  logic       start;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       ate_food;
  logic       hit_wall;
  logic       hit_self;
  logic       step;
  logic [1:0] dir;
  logic       clear_board;
  logic       game_over;
  logic [1:0] state;
  logic [3:0] level;

  modport master (
    input  start, up, down, left, right, ate_food, hit_wall, hit_self,
    output step, dir, clear_board, game_over, state, level
  );

  modport slave (
    output start, up, down, left, right, ate_food, hit_wall, hit_self,
    input  step, dir, clear_board, game_over, state, level
  );
endinterface

// File: rtl/game_sequencer.sv
// Snake game controller: IDLE/INIT/PLAY/OVER FSM, score-dependent move strobe, 2-deep direction queue.
// Optional macro PAUSE_EN: START in PLAY toggles a pause (reported as state code 01).
module game_sequencer #(
  parameter int unsigned BASE_DIV       = 10_000_000,
  parameter int unsigned MIN_DIV        = 2_500_000,
  parameter int unsigned DIV_DEC        = 1_000_000,
  parameter int unsigned FOOD_PER_LEVEL = 5
) (
  input logic              clk,
  input logic              RST,
  game_sequencer_if.master bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_INIT = 2'b01,
    S_PLAY = 2'b10,
    S_OVER = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  dir_q, dir_d;
  logic        step_q, step_d;
  logic        clear_q, clear_d;
  logic [3:0]  level_q, level_d;
  logic [31:0] period_q, period_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] food_q, food_d;
  logic [1:0]  fifo_q [2];
  logic [1:0]  fifo_d [2];
  logic [1:0]  fcnt_q, fcnt_d;
  logic [4:0]  keys_prev_q;

  logic [4:0]  keys_now, key_edge;
  logic        start_edge, has_key, accept, terminal, pop, wr_idx, collision, hold_pause;
  logic [1:0]  key_dir, ref_dir;

`ifdef PAUSE_EN
  logic paused_q, paused_d;
  assign hold_pause = paused_q || (start_edge && !collision);
  assign bus.state  = paused_q ? 2'b01 : state_q;
`else
  assign hold_pause = 1'b0;
  assign bus.state  = state_q;
`endif

  assign keys_now   = {bus.start, bus.up, bus.down, bus.left, bus.right};
  assign key_edge   = keys_now & ~keys_prev_q;
  assign start_edge = key_edge[4];
  assign collision  = bus.hit_wall || bus.hit_self;
  // >= rather than == so a period that shrank below the counter wraps immediately
  assign terminal   = cnt_q >= (period_q - 32'd1);

  always_comb begin
    has_key = 1'b1;
    key_dir = 2'b00;
    if (key_edge[3])      key_dir = 2'b00;
    else if (key_edge[2]) key_dir = 2'b01;
    else if (key_edge[1]) key_dir = 2'b10;
    else if (key_edge[0]) key_dir = 2'b11;
    else                  has_key = 1'b0;
    ref_dir = dir_q;
    if (fcnt_q == 2'd2)      ref_dir = fifo_q[1];
    else if (fcnt_q == 2'd1) ref_dir = fifo_q[0];
    accept = has_key && (key_dir != ref_dir) && (key_dir != (ref_dir ^ 2'b01)) && (fcnt_q != 2'd2);
    pop    = terminal && (fcnt_q != 2'd0);
    wr_idx = (fcnt_q == 2'd1) && !pop;
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    clear_d  = 1'b0;
    level_d  = level_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    food_d   = food_q;
    fifo_d   = fifo_q;
    fcnt_d   = fcnt_q;
`ifdef PAUSE_EN
    paused_d = paused_q;
`endif
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          state_d = S_INIT;
          clear_d = 1'b1;
        end
      end
      S_INIT: begin
        state_d  = S_PLAY;
        dir_d    = 2'b11;
        level_d  = 4'd0;
        period_d = BASE_DIV;
        cnt_d    = 32'd0;
        food_d   = 32'd0;
        fcnt_d   = 2'd0;
      end
      default: begin
        if (hold_pause) begin
`ifdef PAUSE_EN
          paused_d = paused_q ^ start_edge;
`endif
        end else if (collision) begin
          state_d = S_OVER;
        end else begin
          if (terminal) begin
            cnt_d  = 32'd0;
            step_d = 1'b1;
            if (pop) dir_d = fifo_q[0];
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
          if (pop) fifo_d[0] = fifo_q[1];
          if (accept) fifo_d[wr_idx] = key_dir;
          fcnt_d = fcnt_q - {1'b0, pop} + {1'b0, accept};
          if (bus.ate_food) begin
            if (food_q + 32'd1 >= FOOD_PER_LEVEL) begin
              food_d   = 32'd0;
              period_d = (period_q >= MIN_DIV + DIV_DEC) ? period_q - DIV_DEC : MIN_DIV;
              if (level_q != 4'hF) level_d = level_q + 4'd1;
            end else begin
              food_d = food_q + 32'd1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= S_IDLE;
      dir_q       <= 2'b11;
      step_q      <= 1'b0;
      clear_q     <= 1'b0;
      level_q     <= 4'd0;
      period_q    <= BASE_DIV;
      cnt_q       <= 32'd0;
      food_q      <= 32'd0;
      fifo_q[0]   <= 2'b00;
      fifo_q[1]   <= 2'b00;
      fcnt_q      <= 2'd0;
      keys_prev_q <= 5'd0;
`ifdef PAUSE_EN
      paused_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      clear_q     <= clear_d;
      level_q     <= level_d;
      period_q    <= period_d;
      cnt_q       <= cnt_d;
      food_q      <= food_d;
      fifo_q      <= fifo_d;
      fcnt_q      <= fcnt_d;
      keys_prev_q <= keys_now;
`ifdef PAUSE_EN
      paused_q    <= paused_d;
`endif
    end
  end

  assign bus.step        = step_q;
  assign bus.dir         = dir_q;
  assign bus.clear_board = clear_q;
  assign bus.game_over   = (state_q == S_OVER);
  assign bus.level       = level_q;
endmodule
